apb_regfile_slave: RTL and testbench

//   APB completer (responder) holding a small bank of software-visible registers, with programmable wait states.

---
 rtl/apb_regfile_slave.sv | 110 +++++++++++
 tb/tb_apb_regfile_slave.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_regfile_slave.sv
// APB completer: a bank of RW registers plus one read-only status word, with a
// fixed number of wait states inserted before every transfer completes.
//
// state  | meaning
// IDLE   | no transfer in progress, waiting for a setup phase
// ACCESS | setup accepted, counting wait states until PREADY
module apb_regfile_slave #(
  parameter int              DW      = 32,
  parameter int              AW      = 16,
  parameter int              NREG    = 8,
  parameter int              WS      = 1,
  parameter logic [DW-1:0]   RST_VAL = '0
) (
  input  logic                     APBS_CLK,
  input  logic                     APBS_RESETN,
  input  logic                     APBS_PSEL,
  input  logic                     APBS_PENABLE,
  input  logic [AW-1:0]            APBS_PADDR,
  input  logic [DW-1:0]            APBS_PWDATA,
  input  logic                     APBS_PWRITE,
  output logic [DW-1:0]            APBS_PRDATA,
  output logic                     APBS_PREADY,
  output logic                     APBS_PSLVERR,
  output logic [(NREG-1)*DW-1:0]   REG_Q,
  output logic [NREG-2:0]          WR_PULSE,
  input  logic [DW-1:0]            STATUS_I
);

  localparam int BW = $clog2(DW / 8);
  localparam int IW = $clog2(NREG);
  localparam logic [AW-1:0] LOW_MASK = AW'((1 << BW) - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t          state, state_next;
  logic [3:0]      cnt;
  logic            err_q;
  logic            write_q;
  logic [IW-1:0]   idx_q;
  logic [DW-1:0]   regs [NREG-1];

  logic [AW-1:0]   idx;
  logic            illegal;
  logic            setup;
  logic            ready;
  logic            complete;
  logic [DW-1:0]   rdata;

  always_comb begin
    idx      = APBS_PADDR >> BW;
    illegal  = (idx >= AW'(NREG)) || (|(APBS_PADDR & LOW_MASK)) ||
               (APBS_PWRITE && (idx == AW'(NREG - 1)));
    setup    = (state == IDLE) && APBS_PSEL && !APBS_PENABLE;
    ready    = (state == ACCESS) && (cnt == 4'd0);
    complete = ready && APBS_PSEL && APBS_PENABLE;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (APBS_PSEL && !APBS_PENABLE) state_next = ACCESS;
      ACCESS:  if (!APBS_PSEL || complete) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge APBS_CLK) begin
    if (!APBS_RESETN) begin
      state    <= IDLE;
      cnt      <= '0;
      err_q    <= 1'b0;
      write_q  <= 1'b0;
      idx_q    <= '0;
      WR_PULSE <= '0;
      for (int i = 0; i < NREG - 1; i++) regs[i] <= RST_VAL;
    end else begin
      state    <= state_next;
      WR_PULSE <= '0;
      if (setup) begin
        cnt     <= 4'(WS);
        err_q   <= illegal;
        write_q <= APBS_PWRITE;
        idx_q   <= idx[IW-1:0];
      end else if (state == ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // an erroring index may alias a real register after truncation, so err_q gates it
      if (complete && write_q && !err_q) begin
        for (int i = 0; i < NREG - 1; i++) begin
          if (idx_q == IW'(i)) begin
            regs[i]     <= APBS_PWDATA;
            WR_PULSE[i] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    rdata = STATUS_I;
    for (int i = 0; i < NREG - 1; i++) begin
      if (idx_q == IW'(i)) rdata = regs[i];
    end
    APBS_PREADY  = ready;
    APBS_PSLVERR = ready && err_q;
    APBS_PRDATA  = (ready && !err_q) ? rdata : '0;
    for (int i = 0; i < NREG - 1; i++) REG_Q[i*DW +: DW] = regs[i];
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Bench for apb_regfile_slave: three instances (WS=1, 0, 3) on private select
// lines, table vectors, directed corner sequences and a random run vs a model.
module tb_apb_regfile_slave;

  localparam int DW   = 32;
  localparam int AW   = 16;
  localparam int NREG = 8;
  localparam int NRW  = NREG - 1;
  localparam int WSV [3] = '{1, 0, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             resetn  [3];
  logic             psel    [3];
  logic             penable [3];
  logic [AW-1:0]    paddr;
  logic [DW-1:0]    pwdata;
  logic             pwrite;
  logic [DW-1:0]    status;
  logic [DW-1:0]    prdata  [3];
  logic             pready  [3];
  logic             pslverr [3];
  logic [NRW*DW-1:0] reg_q  [3];
  logic [NRW-1:0]   wr_pulse [3];

  apb_regfile_slave #(.DW(DW), .AW(AW), .NREG(NREG), .WS(1)) u_ws1 (
    .APBS_CLK(clk), .APBS_RESETN(resetn[0]), .APBS_PSEL(psel[0]), .APBS_PENABLE(penable[0]),
    .APBS_PADDR(paddr), .APBS_PWDATA(pwdata), .APBS_PWRITE(pwrite), .APBS_PRDATA(prdata[0]),
    .APBS_PREADY(pready[0]), .APBS_PSLVERR(pslverr[0]), .REG_Q(reg_q[0]),
    .WR_PULSE(wr_pulse[0]), .STATUS_I(status));

  apb_regfile_slave #(.DW(DW), .AW(AW), .NREG(NREG), .WS(0)) u_ws0 (
    .APBS_CLK(clk), .APBS_RESETN(resetn[1]), .APBS_PSEL(psel[1]), .APBS_PENABLE(penable[1]),
    .APBS_PADDR(paddr), .APBS_PWDATA(pwdata), .APBS_PWRITE(pwrite), .APBS_PRDATA(prdata[1]),
    .APBS_PREADY(pready[1]), .APBS_PSLVERR(pslverr[1]), .REG_Q(reg_q[1]),
    .WR_PULSE(wr_pulse[1]), .STATUS_I(status));

  apb_regfile_slave #(.DW(DW), .AW(AW), .NREG(NREG), .WS(3)) u_ws3 (
    .APBS_CLK(clk), .APBS_RESETN(resetn[2]), .APBS_PSEL(psel[2]), .APBS_PENABLE(penable[2]),
    .APBS_PADDR(paddr), .APBS_PWDATA(pwdata), .APBS_PWRITE(pwrite), .APBS_PRDATA(prdata[2]),
    .APBS_PREADY(pready[2]), .APBS_PSLVERR(pslverr[2]), .REG_Q(reg_q[2]),
    .WR_PULSE(wr_pulse[2]), .STATUS_I(status));

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mregs [3][NRW];

  typedef struct {
    logic          wr;
    logic [15:0]   addr;
    logic [31:0]   wdata;
    logic          exp_err;
    logic [31:0]   exp_rd;
    logic [NRW-1:0] exp_pulse;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string name, input logic [NRW*DW-1:0] act, input logic [NRW*DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic model_err(input logic wr, input logic [15:0] a);
    int idx;
    idx = int'(a) / 4;
    return (idx >= NREG) || (int'(a) % 4 != 0) || (wr && idx == NREG - 1);
  endfunction

  function automatic logic [NRW*DW-1:0] model_q(input int d);
    logic [NRW*DW-1:0] v;
    for (int i = 0; i < NRW; i++) v[i*DW +: DW] = mregs[d][i];
    return v;
  endfunction

  // Starts at #1 after an edge; returns #1 after the completing edge.
  task automatic xfer(input int d, input logic wr, input logic [15:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int nw, output logic [NRW-1:0] pl);
    paddr = a; pwrite = wr; pwdata = wd;
    psel[d] = 1'b1; penable[d] = 1'b0;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    nw = 0;
    while (!pready[d] && nw < 50) begin
      @(posedge clk); #1;
      nw++;
    end
    chk("pready_seen", pready[d], 1'b1);
    rd = prdata[d];
    er = pslverr[d];
    @(posedge clk); #1;
    pl = wr_pulse[d];
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic run_model(input int d, input logic wr, input logic [15:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er, output logic [NRW-1:0] pl);
    int idx;
    int nw;
    logic e;
    logic [31:0] erd;
    logic [NRW-1:0] epl;
    idx = int'(a) / 4;
    e   = model_err(wr, a);
    if (e) erd = '0;
    else if (idx == NREG - 1) erd = status;
    else erd = mregs[d][idx];
    epl = (wr && !e) ? NRW'(1 << idx) : '0;
    xfer(d, wr, a, wd, rd, er, nw, pl);
    chk("pslverr", er, e);
    if (!wr || e) chk("prdata", rd, erd);
    chk("wr_pulse", pl, epl);
    chk("wait_states", nw, WSV[d]);
    if (wr && !e) mregs[d][idx] = wd;
    chk("reg_q", reg_q[d], model_q(d));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic er;
    logic [NRW-1:0] pl;
    int t0;

    tbl[0]  = '{1'b1, 16'h0008, 32'hDEADBEEF, 1'b0, 32'h0,        7'b0000100};
    tbl[1]  = '{1'b0, 16'h0008, 32'h0,        1'b0, 32'hDEADBEEF, 7'b0000000};
    tbl[2]  = '{1'b0, 16'h001C, 32'h0,        1'b0, 32'h12345678, 7'b0000000};
    tbl[3]  = '{1'b1, 16'h001C, 32'hFFFFFFFF, 1'b1, 32'h0,        7'b0000000};
    tbl[4]  = '{1'b0, 16'h0020, 32'h0,        1'b1, 32'h0,        7'b0000000};
    tbl[5]  = '{1'b0, 16'h0002, 32'h0,        1'b1, 32'h0,        7'b0000000};
    tbl[6]  = '{1'b1, 16'h0000, 32'h11111111, 1'b0, 32'h0,        7'b0000001};
    tbl[7]  = '{1'b1, 16'h0006, 32'h22222222, 1'b1, 32'h0,        7'b0000000};
    tbl[8]  = '{1'b1, 16'h0018, 32'hCAFEF00D, 1'b0, 32'h0,        7'b1000000};
    tbl[9]  = '{1'b0, 16'h0018, 32'h0,        1'b0, 32'hCAFEF00D, 7'b0000000};
    tbl[10] = '{1'b0, 16'h0000, 32'h0,        1'b0, 32'h11111111, 7'b0000000};
    tbl[11] = '{1'b0, 16'h0004, 32'h0,        1'b0, 32'h0,        7'b0000000};
    tbl[12] = '{1'b1, 16'h0040, 32'h33333333, 1'b1, 32'h0,        7'b0000000};
    tbl[13] = '{1'b0, 16'h0008, 32'h0,        1'b0, 32'hDEADBEEF, 7'b0000000};

    paddr = '0; pwdata = '0; pwrite = 1'b0; status = 32'h12345678;
    for (int d = 0; d < 3; d++) begin
      resetn[d] = 1'b0; psel[d] = 1'b0; penable[d] = 1'b0;
      for (int i = 0; i < NRW; i++) mregs[d][i] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_reg_q", reg_q[d], '0);
      chk("rst_pready", pready[d], 1'b0);
      chk("rst_pslverr", pslverr[d], 1'b0);
      chk("rst_wr_pulse", wr_pulse[d], '0);
      chk("rst_prdata", prdata[d], '0);
      resetn[d] = 1'b1;
    end
    @(posedge clk); #1;

    // PENABLE without a preceding setup phase must not start a transfer
    psel[0] = 1'b1; penable[0] = 1'b1; paddr = 16'h0000; pwrite = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_penable_pready", pready[0], 1'b0);
    end
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 14; k++) begin
      run_model(0, tbl[k].wr, tbl[k].addr, tbl[k].wdata, rd, er, pl);
      chk("tbl_err", er, tbl[k].exp_err);
      if (!tbl[k].wr || tbl[k].exp_err) chk("tbl_rdata", rd, tbl[k].exp_rd);
      chk("tbl_pulse", pl, tbl[k].exp_pulse);
      @(posedge clk); #1;
      chk("tbl_pulse_one_cycle", wr_pulse[0], '0);
    end

    // Back-to-back writes with WS=0: two cycles each, pulses on separate cycles
    t0 = cyc;
    run_model(1, 1'b1, 16'h0000, 32'hA5A5A5A5, rd, er, pl);
    chk("b2b_pulse0", pl, 7'b0000001);
    run_model(1, 1'b1, 16'h0004, 32'h5A5A5A5A, rd, er, pl);
    chk("b2b_pulse1", pl, 7'b0000010);
    chk("b2b_cycles", cyc - t0, 4);
    @(posedge clk); #1;

    // Abort on WS=3: drop PSEL mid-wait, then reset mid-ACCESS on a retry
    run_model(2, 1'b1, 16'h0010, 32'h00000077, rd, er, pl);
    paddr = 16'h000C; pwrite = 1'b1; pwdata = 32'hAAAA5555;
    psel[2] = 1'b1; penable[2] = 1'b0;
    @(posedge clk); #1;
    penable[2] = 1'b1;
    chk("abort_wait0", pready[2], 1'b0);
    @(posedge clk); #1;
    chk("abort_wait1", pready[2], 1'b0);
    psel[2] = 1'b0; penable[2] = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("abort_pready", pready[2], 1'b0);
      chk("abort_pulse", wr_pulse[2], '0);
      chk("abort_reg_q", reg_q[2], model_q(2));
    end
    psel[2] = 1'b1; penable[2] = 1'b0;
    @(posedge clk); #1;
    penable[2] = 1'b1;
    @(posedge clk); #1;
    resetn[2] = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < NRW; i++) mregs[2][i] = '0;
    chk("rstabort_pready", pready[2], 1'b0);
    chk("rstabort_pulse", wr_pulse[2], '0);
    chk("rstabort_reg_q", reg_q[2], model_q(2));
    resetn[2] = 1'b1; psel[2] = 1'b0; penable[2] = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("rstabort_idle", pready[2], 1'b0);
    end
    run_model(2, 1'b1, 16'h000C, 32'h5555AAAA, rd, er, pl);
    chk("retry_pulse", pl, 7'b0001000);
    run_model(2, 1'b0, 16'h000C, 32'h0, rd, er, pl);
    chk("retry_read", rd, 32'h5555AAAA);

    for (int n = 0; n < 300; n++) begin
      int d;
      logic [15:0] a;
      d = int'($urandom_range(0, 2));
      status = $urandom;
      if ($urandom_range(0, 3) == 0) a = 16'($urandom_range(0, 63));
      else a = 16'($urandom_range(0, NREG - 1) * 4);
      run_model(d, 1'($urandom_range(0, 1)), a, $urandom, rd, er, pl);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
        chk("rand_pulse_clear", wr_pulse[d], '0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
